// File: rtl/alu_display_ctrl.sv
// rtl/alu_display_ctrl.sv - debounced add/sub calculator with 4-digit hex seven-segment scan
module alu_display_ctrl #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int SCAN_BITS       = 18
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw,
   input  logic             store1,
   input  logic             store2,
   input  logic             add,
   input  logic             sub,
   output logic [WIDTH-1:0] Led,
   output logic             carry,
   output logic             zero,
   output logic [6:0]       seg,
   output logic [3:0]       an
);

   localparam int             CW   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CMAX = CW'(DEBOUNCE_CYCLES - 1);
   // number of hex digits that carry result bits; the rest are blanked
   localparam logic [2:0]     NDIG = 3'((WIDTH + 3) / 4);

   // button order: bit 0 = store1 (highest priority) .. bit 3 = sub
   logic [3:0]    raw;
   logic [3:0]    sync1, sync2, db, pulse;
   logic [CW-1:0] cnt [4];

   logic [WIDTH-1:0] a, b, result;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] diff;

   logic [SCAN_BITS-1:0] scan;
   logic [1:0]           d;
   logic [15:0]          res16;
   logic [3:0]           nib;
   logic [6:0]           hex;

   assign Led = sw;
   assign raw = {sub, add, store2, store1};

   // synchronise, debounce and edge-detect each button independently
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         pulse <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 4; i++) begin
            pulse[i] <= 1'b0;
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CMAX) begin
               cnt[i]   <= '0;
               db[i]    <= ~db[i];
               // only the press direction produces a command
               pulse[i] <= ~db[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = a - b;

   // execute at most one command per cycle, highest priority wins
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a      <= '0;
         b      <= '0;
         result <= '0;
         carry  <= 1'b0;
         zero   <= 1'b1;
      end else if (pulse[0]) begin
         a      <= sw;
         result <= sw;
         carry  <= 1'b0;
         zero   <= (sw == '0);
      end else if (pulse[1]) begin
         b      <= sw;
         result <= sw;
         carry  <= 1'b0;
         zero   <= (sw == '0);
      end else if (pulse[2]) begin
         result <= sum[WIDTH-1:0];
         carry  <= sum[WIDTH];
         zero   <= (sum[WIDTH-1:0] == '0);
      end else if (pulse[3]) begin
         result <= diff;
         carry  <= (a < b);
         zero   <= (diff == '0);
      end
   end

   assign d     = scan[SCAN_BITS-1 -: 2];
   assign res16 = 16'(result);
   assign nib   = res16[{d, 2'b00} +: 4];

   // active-low hex glyphs, bit order {g,f,e,d,c,b,a}
   always_comb begin
      hex = 7'b1111111;
      case (nib)
         4'h0: hex = 7'b1000000;
         4'h1: hex = 7'b1111001;
         4'h2: hex = 7'b0100100;
         4'h3: hex = 7'b0110000;
         4'h4: hex = 7'b0011001;
         4'h5: hex = 7'b0010010;
         4'h6: hex = 7'b0000010;
         4'h7: hex = 7'b1111000;
         4'h8: hex = 7'b0000000;
         4'h9: hex = 7'b0010000;
         4'hA: hex = 7'b0001000;
         4'hB: hex = 7'b0000011;
         4'hC: hex = 7'b1000110;
         4'hD: hex = 7'b0100001;
         4'hE: hex = 7'b0000110;
         4'hF: hex = 7'b0001110;
         default: hex = 7'b1111111;
      endcase
   end

   // free-running scan; anode and segments registered one cycle behind the counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan <= '0;
         an   <= 4'b1111;
         seg  <= 7'b1111111;
      end else begin
         scan <= scan + 1'b1;
         an   <= ~(4'b0001 << d);
         seg  <= ({1'b0, d} < NDIG) ? hex : 7'b1111111;
      end
   end

endmodule

// File: tb/tb_alu_display_ctrl.sv
// tb/tb_alu_display_ctrl.sv - randomized self-checking bench for alu_display_ctrl
module tb_alu_display_ctrl;

   localparam int W  = 8;
   localparam int DC = 4;
   localparam int SB = 4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] sw;
   logic         store1, store2, add, sub;
   logic [W-1:0] Led;
   logic         carry, zero;
   logic [6:0]   seg;
   logic [3:0]   an;

   int tests;
   int fails;
   int k;                       // clock edges since reset released
   int ma, mb, mres, mcarry;    // reference model state
   logic [6:0] hexrom [16];

   alu_display_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .SCAN_BITS(SB)) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw),
      .store1(store1), .store2(store2), .add(add), .sub(sub),
      .Led(Led), .carry(carry), .zero(zero), .seg(seg), .an(an)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (!rst_n) k <= 0;
      else        k <= k + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      ma = 0; mb = 0; mres = 0; mcarry = 0;
   endtask

   // command semantics with plain integer arithmetic and fixed priority
   task automatic model_apply(input logic [3:0] mask, input int v);
      if (mask[0]) begin
         ma = v; mres = v; mcarry = 0;
      end else if (mask[1]) begin
         mb = v; mres = v; mcarry = 0;
      end else if (mask[2]) begin
         mres = (ma + mb) % 256;
         mcarry = (ma + mb >= 256) ? 1 : 0;
      end else if (mask[3]) begin
         mres = (ma - mb + 256) % 256;
         mcarry = (ma < mb) ? 1 : 0;
      end
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_carry"}, int'(carry), mcarry);
      check({tag, "_zero"}, int'(zero), (mres == 0) ? 1 : 0);
   endtask

   // one full scan period of anode/segment checks against the model result
   task automatic check_display(input string tag);
      int dg, ean, eseg;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (k == 0) begin
            ean = 15; eseg = 7'h7F;
         end else begin
            dg   = ((k - 1) % 16) / 4;
            ean  = 15 & ~(1 << dg);
            eseg = (dg < 2) ? int'(hexrom[(mres >> (4 * dg)) & 15]) : 7'h7F;
         end
         check({tag, "_an"}, int'(an), ean);
         check({tag, "_seg"}, int'(seg), eseg);
      end
   endtask

   task automatic press(input logic [3:0] mask, input int v, input int hold);
      sw = W'(v);
      {sub, add, store2, store1} = mask;
      repeat (hold) @(negedge clk);
      model_apply(mask, v);
      {sub, add, store2, store1} = 4'b0000;
      repeat (10) @(negedge clk);
   endtask

   task automatic op_check(input string tag, input logic [3:0] mask, input int v);
      press(mask, v, 10);
      check_flags(tag);
      check({tag, "_led"}, int'(Led), v);
      check_display(tag);
   endtask

   initial begin
      logic [3:0] m;
      int v;
      tests = 0; fails = 0;
      hexrom = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      model_reset();
      rst_n = 1'b0; sw = '0;
      {sub, add, store2, store1} = 4'b0000;
      repeat (3) @(negedge clk);
      check("rst_an", int'(an), 4'hF);
      check("rst_seg", int'(seg), 7'h7F);
      check("rst_zero", int'(zero), 1);
      check("rst_carry", int'(carry), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("first_an", int'(an), 4'hE);
      check("first_seg", int'(seg), 7'b1000000);

      // bounce rejection: short high pulses never reach the debounce threshold
      sw = 8'h3C;
      for (int i = 0; i < 10; i++) begin
         store1 = (i % 2 == 0);
         repeat (2) @(negedge clk);
      end
      store1 = 1'b0;
      repeat (6) @(negedge clk);
      check_flags("bounce");
      check_display("bounce");
      op_check("store_3c", 4'b0001, 8'h3C);

      op_check("a_f0", 4'b0001, 8'hF0);
      op_check("b_20", 4'b0010, 8'h20);
      op_check("add1", 4'b0100, 0);
      op_check("a_80", 4'b0001, 8'h80);
      op_check("b_80", 4'b0010, 8'h80);
      op_check("add2", 4'b0100, 0);
      op_check("a_05", 4'b0001, 8'h05);
      op_check("b_07", 4'b0010, 8'h07);
      op_check("sub1", 4'b1000, 0);
      op_check("a_07", 4'b0001, 8'h07);
      op_check("b_05", 4'b0010, 8'h05);
      op_check("sub2", 4'b1000, 0);

      // store1 and add together, held long: only the store may execute
      press(4'b0010, 8'h20, 10);
      press(4'b0101, 8'h11, 110);
      check_flags("simul");
      check_display("simul");

      for (int i = 0; i < 24; i++) begin
         m = 4'b0001 << $urandom_range(0, 3);
         if ($urandom_range(0, 4) == 0) m = 4'($urandom_range(1, 15));
         v = int'($urandom_range(0, 255));
         op_check("rand", m, v);
      end

      // reset while a debounce and the scan are in progress
      sw = 8'h77; store1 = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b0; store1 = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      check("midrst_an", int'(an), 4'hF);
      check("midrst_seg", int'(seg), 7'h7F);
      check_flags("midrst");
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_first_an", int'(an), 4'hE);
      store1 = 1'b1;
      repeat (DC + 2) @(negedge clk);
      check("lat_early_zero", int'(zero), 1);
      @(negedge clk);
      check("lat_done_zero", int'(zero), 0);
      model_apply(4'b0001, 8'h77);
      repeat (3) @(negedge clk);
      store1 = 1'b0;
      repeat (10) @(negedge clk);
      check_flags("post_rst");
      check_display("post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
